// File: rtl/led_trail_fader.sv
// rtl/led_trail_fader.sv - per-LED afterglow PWM fader between the sweep generator and the board LEDs
module led_trail_fader #(
    parameter int   CLK_IN_MHZ   = 125,
    parameter int   PWM_WIDTH    = 6,
    parameter int   DECAY_STEP   = 8,
    parameter int   DECAY_HZ     = 200,
    parameter logic IN_POLARITY  = 1'b0,
    parameter logic LED_POLARITY = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] led_pattern_i,
    input  logic       fade_en_i,
    output logic [7:0] led_o
);

    localparam logic [PWM_WIDTH-1:0] MAX     = {PWM_WIDTH{1'b1}};
    localparam int                   DIV     = CLK_IN_MHZ * 1_000_000 / DECAY_HZ;
    localparam logic [7:0]           LED_OFF = {8{~LED_POLARITY}};

    // Decay step clipped to MAX: a step at or above full scale makes
    // "b > STEP" always false, so the channel drops straight to 0.
    localparam logic [PWM_WIDTH-1:0] STEP =
        (DECAY_STEP >= int'(MAX)) ? MAX : PWM_WIDTH'(DECAY_STEP);

    logic [7:0]           on;
    logic [7:0]           lit;
    logic                 decay_tick;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [PWM_WIDTH-1:0] bright [8];

    // Normalise the incoming pattern to active-high "LED requested on"
    assign on = IN_POLARITY ? led_pattern_i : ~led_pattern_i;

`ifdef SIM
    assign decay_tick = 1'b1;
`else
    generate
        if (DIV <= 1) begin : g_no_prescale
            assign decay_tick = 1'b1;
        end else begin : g_prescale
            localparam int            CW   = $clog2(DIV);
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] pre_cnt;

            assign decay_tick = (pre_cnt == LAST);

            // Decay prescaler: counts 0..DIV-1, wrapping on the tick cycle
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pre_cnt <= '0;
                end else if (decay_tick) begin
                    pre_cnt <= '0;
                end else begin
                    pre_cnt <= pre_cnt + CW'(1);
                end
            end
        end
    endgenerate
`endif

    // Brightness: requested LEDs snap to full scale (beating a decay tick),
    // dark LEDs lose STEP per tick and saturate at 0; runs in bypass too
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                bright[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (on[i]) begin
                    bright[i] <= MAX;
                end else if (decay_tick) begin
                    bright[i] <= (bright[i] > STEP) ? (bright[i] - STEP) : '0;
                end
            end
        end
    end

    // Shared free-running PWM ramp for all eight channels
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
        end
    end

    // Per-channel lit decision: full scale is forced to 100% duty,
    // otherwise compare against the ramp; bypass follows the pattern
    always_comb begin
        lit = '0;
        for (int i = 0; i < 8; i++) begin
            if (fade_en_i) begin
                lit[i] = (bright[i] == MAX) || (pwm_cnt < bright[i]);
            end else begin
                lit[i] = on[i];
            end
        end
    end

    // Registered LED drive in the board's polarity
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_o <= LED_OFF;
        end else begin
            led_o <= LED_POLARITY ? lit : ~lit;
        end
    end

endmodule

// File: tb/tb_led_trail_fader.sv
// tb/tb_led_trail_fader.sv - directed self-checking bench for led_trail_fader
`timescale 1ns/1ps
module tb_led_trail_fader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fade_en = 1'b1;
    logic [7:0] pattern_a = 8'hFF;
    logic [7:0] pattern_b = 8'hFF;
    logic [7:0] pattern_c = 8'h00;
    logic [7:0] led_a;
    logic [7:0] led_b;
    logic [7:0] led_c;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Clock edges since reset release; the PWM ramp and prescaler phase follow from it
    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
    end

    // Decay every cycle
    led_trail_fader #(
        .CLK_IN_MHZ(1), .PWM_WIDTH(3), .DECAY_STEP(3), .DECAY_HZ(1_000_000),
        .IN_POLARITY(1'b0), .LED_POLARITY(1'b0)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .led_pattern_i(pattern_a),
        .fade_en_i(fade_en), .led_o(led_a)
    );

    // Decay every 16 cycles
    led_trail_fader #(
        .CLK_IN_MHZ(1), .PWM_WIDTH(3), .DECAY_STEP(3), .DECAY_HZ(62_500),
        .IN_POLARITY(1'b0), .LED_POLARITY(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .led_pattern_i(pattern_b),
        .fade_en_i(fade_en), .led_o(led_b)
    );

    // Active-high in and out
    led_trail_fader #(
        .CLK_IN_MHZ(1), .PWM_WIDTH(3), .DECAY_STEP(3), .DECAY_HZ(1_000_000),
        .IN_POLARITY(1'b1), .LED_POLARITY(1'b1)
    ) dut_c (
        .clk_i(clk), .rst_i(rst), .led_pattern_i(pattern_c),
        .fade_en_i(fade_en), .led_o(led_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while (((cyc % 16) != ph) && (n < 40)) begin
            tick();
            n++;
        end
        total++;
        if ((cyc % 16) != ph) begin
            bad++;
            $display("FAIL wait_phase cyc=%0d required phase %0d", cyc, ph);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if (led_a !== 8'hFF || led_b !== 8'hFF || led_c !== 8'h00) begin
            bad++;
            $display("FAIL reset_async a=%h b=%h c=%h required ff ff 00", led_a, led_b, led_c);
        end
        pattern_a = 8'hFE;
        ticks(3);
        total++;
        if (led_a !== 8'hFF) begin
            bad++;
            $display("FAIL reset_held led_a=%h required ff", led_a);
        end
        pattern_a = 8'hFF;
        @(posedge clk);
        #1 rst = 1'b0;
        ticks(4);
        total++;
        if (led_a !== 8'hFF || led_b !== 8'hFF) begin
            bad++;
            $display("FAIL reset_release a=%h b=%h required ff ff", led_a, led_b);
        end
    endtask

    task automatic test_full_on();
        int errs;
        fade_en = 1'b1;
        pattern_a = 8'hFE;
        tick();
        total++;
        if (led_a !== 8'hFF) begin
            bad++;
            $display("FAIL full_on_latency led_a=%h required ff", led_a);
        end
        tick();
        total++;
        if (led_a !== 8'hFE) begin
            bad++;
            $display("FAIL full_on_first led_a=%h required fe", led_a);
        end
        errs = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (led_a !== 8'hFE) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL full_on_hold bad_cycles=%0d required 0", errs);
        end
    endtask

    task automatic test_decay();
        logic [2:0] seq [4];
        seq[0] = 3'd7; seq[1] = 3'd4; seq[2] = 3'd1; seq[3] = 3'd0;
        total++;
        if (dut_a.bright[0] !== seq[0]) begin
            bad++;
            $display("FAIL decay_b0 b=%0d required %0d", dut_a.bright[0], seq[0]);
        end
        pattern_a = 8'hFF;
        for (int k = 1; k < 4; k++) begin
            tick();
            total++;
            if (dut_a.bright[0] !== seq[k]) begin
                bad++;
                $display("FAIL decay_b%0d b=%0d required %0d", k, dut_a.bright[0], seq[k]);
            end
        end
        ticks(2);
        total++;
        if (dut_a.bright[0] !== 3'd0 || led_a !== 8'hFF) begin
            bad++;
            $display("FAIL decay_floor b=%0d led_a=%h required 0 ff", dut_a.bright[0], led_a);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] prev;
        logic [7:0] p;
        logic [7:0] lit_e;
        int pw;
        fade_en = 1'b0;
        prev = 8'hFF;
        for (int j = 0; j < 8; j++) begin
            p = ~(8'h01 << j);
            pattern_a = p;
            if (j < 6) begin
                total++;
                if (led_a !== prev) begin
                    bad++;
                    $display("FAIL bypass_pre%0d led_a=%h required %h", j, led_a, prev);
                end
            end
            tick();
            if (j < 6) begin
                total++;
                if (led_a !== p) begin
                    bad++;
                    $display("FAIL bypass_step%0d led_a=%h required %h", j, led_a, p);
                end
            end else begin
                pw = (cyc - 1) % 8;
                lit_e = 8'h00;
                lit_e[j-1] = 1'b1;
                lit_e[j-2] = (pw < 4);
                lit_e[j-3] = (pw < 1);
                total++;
                if (led_a !== ~lit_e) begin
                    bad++;
                    $display("FAIL trail_step%0d led_a=%h required %h", j, led_a, ~lit_e);
                end
            end
            if (j == 5) fade_en = 1'b1;
            prev = p;
        end
        pattern_a = 8'hFF;
    endtask

    task automatic test_priority();
        wait_phase(15);
        pattern_b = 8'hF7;
        tick();
        pattern_b = 8'hFF;
        wait_phase(15);
        tick();
        total++;
        if (dut_b.bright[3] !== 3'd4) begin
            bad++;
            $display("FAIL priority_decay b3=%0d required 4", dut_b.bright[3]);
        end
        wait_phase(15);
        pattern_b = 8'hF7;
        tick();
        total++;
        if (dut_b.bright[3] !== 3'd7) begin
            bad++;
            $display("FAIL priority_on_tick b3=%0d required 7", dut_b.bright[3]);
        end
        tick();
        total++;
        if (led_b !== 8'hF7) begin
            bad++;
            $display("FAIL priority_led led_b=%h required f7", led_b);
        end
        pattern_b = 8'hFF;
        ticks(48);
    endtask

    task automatic test_duty();
        int on_cnt;
        int other;
        int exp_on [3];
        exp_on[0] = 4; exp_on[1] = 1; exp_on[2] = 0;
        wait_phase(15);
        pattern_b = 8'hFE;
        tick();
        pattern_b = 8'hFF;
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (led_b === 8'hFE) on_cnt++;
        end
        total++;
        if (on_cnt != 16) begin
            bad++;
            $display("FAIL duty_full lit=%0d of 16 required 16", on_cnt);
        end
        for (int s = 0; s < 3; s++) begin
            on_cnt = 0;
            other = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (led_b[0] === 1'b0) on_cnt++;
                if (led_b[7:1] !== 7'h7F) other++;
            end
            total++;
            if (on_cnt != exp_on[s] || other != 0) begin
                bad++;
                $display("FAIL duty_level%0d lit=%0d of 8 required %0d (stray=%0d)",
                         s, on_cnt, exp_on[s], other);
            end
            ticks(8);
        end
    endtask

    task automatic test_reset_mid();
        int errs;
        pattern_b = 8'hFE;
        ticks(3);
        total++;
        if (led_b !== 8'hFE) begin
            bad++;
            $display("FAIL mid_lit led_b=%h required fe", led_b);
        end
        pattern_b = 8'hFF;
        tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if (led_b !== 8'hFF || led_a !== 8'hFF) begin
            bad++;
            $display("FAIL mid_reset_async b=%h a=%h required ff ff", led_b, led_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (led_b !== 8'hFF) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL mid_no_resume lit_cycles=%0d required 0", errs);
        end
    endtask

    task automatic test_polarity();
        int errs;
        fade_en = 1'b1;
        pattern_c = 8'h01;
        tick();
        total++;
        if (led_c !== 8'h00) begin
            bad++;
            $display("FAIL pol_latency led_c=%h required 00", led_c);
        end
        tick();
        total++;
        if (led_c !== 8'h01) begin
            bad++;
            $display("FAIL pol_on led_c=%h required 01", led_c);
        end
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (led_c !== 8'h01) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL pol_hold bad_cycles=%0d required 0", errs);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (led_c !== 8'h00) begin
            bad++;
            $display("FAIL pol_reset led_c=%h required 00", led_c);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        pattern_c = 8'h00;
        ticks(2);
    endtask

    initial begin
        test_reset();
        test_full_on();
        test_decay();
        test_bypass();
        test_priority();
        test_duty();
        test_polarity();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
